memory_core: RTL and testbench

// - Synchronous clocked replacement for the CSP spike/filter memory of the SNN accelerator.
// - Stores one DATA_W word per (timestep T, row x, column y); the memory wrapper issues

---
 rtl/memory_core.sv | 116 +++++++++++
 tb/tb_memory_core.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_core.sv
// Clocked T/x/y-addressed word store with one request port and one read-response register.
// Optional MEM_ERRCNT_EN adds a saturating 16-bit counter of out-of-range requests (err_cnt).
module memory_core #(
    parameter int DATA_W = 32,
    parameter int T_DIM  = 10,
    parameter int X_DIM  = 25,
    parameter int Y_DIM  = 25
) (
`ifdef MEM_ERRCNT_EN
    output logic [15:0]       err_cnt,
`endif
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [DATA_W-1:0] req_t,
    input  logic [DATA_W-1:0] req_x,
    input  logic [DATA_W-1:0] req_y,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              addr_err
);

    localparam int DEPTH = T_DIM * X_DIM * Y_DIM;
    localparam int AW    = $clog2(DEPTH);

    localparam logic [AW-1:0] X_AW = AW'(X_DIM);
    localparam logic [AW-1:0] Y_AW = AW'(Y_DIM);

    logic [DATA_W-1:0] mem [DEPTH];

    logic              in_range;
    logic [AW-1:0]     addr;
    logic              accept;
    logic              wr_en;
    logic              rd_accept;
    logic [DATA_W-1:0] rd_word;

    logic              rsp_valid_d, rsp_valid_q;
    logic [DATA_W-1:0] rsp_rdata_d, rsp_rdata_q;
    logic              addr_err_d,  addr_err_q;

    // Handshakes: a transfer happens on a rising edge where valid & ready are both high.
    // req_ready depends only on the response register and rsp_ready, never on req_valid.
    always_comb begin
        in_range  = (req_t < DATA_W'(T_DIM)) && (req_x < DATA_W'(X_DIM)) &&
                    (req_y < DATA_W'(Y_DIM));
        addr      = (req_t[AW-1:0] * X_AW + req_x[AW-1:0]) * Y_AW + req_y[AW-1:0];
        req_ready = ~rsp_valid_q | rsp_ready;
        accept    = req_valid & req_ready;
        wr_en     = accept & req_write & in_range;
        rd_accept = accept & ~req_write;
        rd_word   = in_range ? mem[addr] : '0;
    end

    always_comb begin
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        addr_err_d  = accept & ~in_range;
        if (rd_accept) begin
            rsp_valid_d = 1'b1;
            rsp_rdata_d = rd_word;
        end else if (rsp_valid_q && rsp_ready) begin
            rsp_valid_d = 1'b0;
            rsp_rdata_d = '0;
        end
    end

    // Array contents survive reset; only writes seen outside reset land.
    always_ff @(posedge clk) begin
        if (rst_n && wr_en) begin
            mem[addr] <= req_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            addr_err_q  <= 1'b0;
        end else begin
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            addr_err_q  <= addr_err_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign addr_err  = addr_err_q;

`ifdef MEM_ERRCNT_EN
    logic [15:0] err_cnt_d, err_cnt_q;

    always_comb begin
        err_cnt_d = err_cnt_q;
        if (addr_err_d && (err_cnt_q != 16'hFFFF)) begin
            err_cnt_d = err_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_cnt_q <= '0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_memory_core.sv
// Directed bench for memory_core: reset, write/read, corners, stall, back-to-back,
// out-of-range handling and reset mid-response (err_cnt checked when MEM_ERRCNT_EN is set).
module tb_memory_core;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         req_valid;
    logic         req_ready;
    logic         req_write;
    logic [W-1:0] req_t;
    logic [W-1:0] req_x;
    logic [W-1:0] req_y;
    logic [W-1:0] req_wdata;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [W-1:0] rsp_rdata;
    logic         addr_err;
`ifdef MEM_ERRCNT_EN
    logic [15:0]  err_cnt;
`endif

    int n_cmp = 0;
    int n_bad = 0;
    logic [W-1:0] exp_q[$];

    memory_core dut (
`ifdef MEM_ERRCNT_EN
        .err_cnt   (err_cnt),
`endif
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_t     (req_t),
        .req_x     (req_x),
        .req_y     (req_y),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .addr_err  (addr_err)
    );

    // clock / reset / watchdog
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // driver tasks: present a request at the negedge, return 1 time unit after the accepting edge
    task automatic drive_req(input logic w, input logic [W-1:0] t, input logic [W-1:0] x,
                             input logic [W-1:0] y, input logic [W-1:0] d);
        @(negedge clk);
        req_valid = 1'b1;
        req_write = w;
        req_t     = t;
        req_x     = x;
        req_y     = y;
        req_wdata = d;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_write = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_t     = '0;
        req_x     = '0;
        req_y     = '0;
        req_wdata = '0;
        rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL reset_rsp_valid got %b exp 0", rsp_valid); end
        n_cmp++; if (rsp_rdata !== 32'h0) begin n_bad++; $display("FAIL reset_rsp_rdata got %h exp 0", rsp_rdata); end
        n_cmp++; if (addr_err !== 1'b0) begin n_bad++; $display("FAIL reset_addr_err got %b exp 0", addr_err); end
        n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL reset_req_ready got %b exp 1", req_ready); end
`ifdef MEM_ERRCNT_EN
        n_cmp++; if (err_cnt !== 16'h0) begin n_bad++; $display("FAIL reset_err_cnt got %0d exp 0", err_cnt); end
`endif
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_write_read;
        drive_req(1'b1, 0, 0, 0, 32'hDEADBEEF);
        n_cmp++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL wr_no_rsp got %b exp 0", rsp_valid); end
        drive_req(1'b0, 0, 0, 0, 32'h0);
        n_cmp++; if (rsp_valid !== 1'b1) begin n_bad++; $display("FAIL rd_rsp_valid got %b exp 1", rsp_valid); end
        n_cmp++; if (rsp_rdata !== 32'hDEADBEEF) begin n_bad++; $display("FAIL rd_rsp_rdata got %h exp deadbeef", rsp_rdata); end
        n_cmp++; if (addr_err !== 1'b0) begin n_bad++; $display("FAIL rd_addr_err got %b exp 0", addr_err); end
        idle_cycles(1);
        n_cmp++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL rd_rsp_taken got %b exp 0", rsp_valid); end
        n_cmp++; if (rsp_rdata !== 32'h0) begin n_bad++; $display("FAIL rd_rdata_cleared got %h exp 0", rsp_rdata); end
    endtask

    task automatic test_corners;
        logic [W-1:0] exp_d;
        for (int t = 0; t < 10; t++) begin
            exp_d = (t == 9) ? 32'h1 : (32'hA000_0000 + W'(t));
            drive_req(1'b1, W'(t), 24, 24, exp_d);
        end
        for (int t = 0; t < 10; t++) begin
            exp_d = (t == 9) ? 32'h1 : (32'hA000_0000 + W'(t));
            drive_req(1'b0, W'(t), 24, 24, 32'h0);
            n_cmp++;
            if (rsp_valid !== 1'b1 || rsp_rdata !== exp_d) begin
                n_bad++;
                $display("FAIL corner_t%0d got v=%b d=%h exp v=1 d=%h", t, rsp_valid, rsp_rdata, exp_d);
            end
        end
        drive_req(1'b0, 0, 0, 0, 32'h0);
        n_cmp++; if (rsp_rdata !== 32'hDEADBEEF) begin n_bad++; $display("FAIL corner_origin got %h exp deadbeef", rsp_rdata); end
        idle_cycles(1);
    endtask

    task automatic test_stall;
        @(negedge clk);
        rsp_ready = 1'b0;
        drive_req(1'b0, 0, 0, 0, 32'h0);
        // a competing read is held on the port while the response is stalled
        req_valid = 1'b1;
        req_write = 1'b0;
        req_t     = 9;
        req_x     = 24;
        req_y     = 24;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_cmp++;
            if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hDEADBEEF || req_ready !== 1'b0) begin
                n_bad++;
                $display("FAIL stall_c%0d got v=%b d=%h rdy=%b exp v=1 d=deadbeef rdy=0",
                         i, rsp_valid, rsp_rdata, req_ready);
            end
        end
        rsp_ready = 1'b1;
        #1;
        n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL stall_release_ready got %b exp 1", req_ready); end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        n_cmp++;
        if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h1) begin
            n_bad++;
            $display("FAIL stall_reload got v=%b d=%h exp v=1 d=1", rsp_valid, rsp_rdata);
        end
        idle_cycles(1);
        n_cmp++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL stall_drain got %b exp 0", rsp_valid); end
    endtask

    task automatic test_back_to_back;
        logic [W-1:0] exp_d;
        rsp_ready = 1'b1;
        for (int t = 0; t < 4; t++) begin
            @(negedge clk);
            req_valid = 1'b1;
            req_write = 1'b0;
            req_t     = W'(t);
            req_x     = 24;
            req_y     = 24;
            exp_q.push_back(32'hA000_0000 + W'(t));
            n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL b2b_ready_%0d got %b exp 1", t, req_ready); end
            @(posedge clk);
            #1;
            exp_d = exp_q.pop_front();
            n_cmp++;
            if (rsp_valid !== 1'b1 || rsp_rdata !== exp_d) begin
                n_bad++;
                $display("FAIL b2b_rsp_%0d got v=%b d=%h exp v=1 d=%h", t, rsp_valid, rsp_rdata, exp_d);
            end
        end
        req_valid = 1'b0;
        idle_cycles(1);
        n_cmp++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL b2b_drain got %b exp 0", rsp_valid); end
    endtask

    task automatic test_addr_err;
        // (0,25,0) would alias (1,0,0) and (0,0,30) would alias (0,1,5) if ranges were ignored
        drive_req(1'b1, 1, 0, 0, 32'h1111_1111);
        drive_req(1'b1, 0, 1, 5, 32'h2222_2222);
        n_cmp++; if (addr_err !== 1'b0) begin n_bad++; $display("FAIL err_inrange_wr got %b exp 0", addr_err); end
        drive_req(1'b1, 0, 25, 0, 32'h5555_5555);
        n_cmp++; if (addr_err !== 1'b1) begin n_bad++; $display("FAIL err_wr_x25 got %b exp 1", addr_err); end
        n_cmp++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL err_wr_no_rsp got %b exp 0", rsp_valid); end
        idle_cycles(1);
        n_cmp++; if (addr_err !== 1'b0) begin n_bad++; $display("FAIL err_pulse_end got %b exp 0", addr_err); end
        drive_req(1'b0, 1, 0, 0, 32'h0);
        n_cmp++; if (rsp_rdata !== 32'h1111_1111) begin n_bad++; $display("FAIL err_no_alias_wr got %h exp 11111111", rsp_rdata); end
        drive_req(1'b0, 0, 0, 30, 32'h0);
        n_cmp++;
        if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h0 || addr_err !== 1'b1) begin
            n_bad++;
            $display("FAIL err_rd_y30 got v=%b d=%h e=%b exp v=1 d=0 e=1", rsp_valid, rsp_rdata, addr_err);
        end
`ifdef MEM_ERRCNT_EN
        n_cmp++; if (err_cnt !== 16'd2) begin n_bad++; $display("FAIL err_cnt_two got %0d exp 2", err_cnt); end
`endif
        drive_req(1'b0, 32'h0001_0000, 0, 0, 32'h0);
        n_cmp++;
        if (rsp_rdata !== 32'h0 || addr_err !== 1'b1) begin
            n_bad++;
            $display("FAIL err_rd_bigT got d=%h e=%b exp d=0 e=1", rsp_rdata, addr_err);
        end
        idle_cycles(1);
`ifdef MEM_ERRCNT_EN
        n_cmp++; if (err_cnt !== 16'd3) begin n_bad++; $display("FAIL err_cnt_three got %0d exp 3", err_cnt); end
`endif
        drive_req(1'b0, 0, 1, 5, 32'h0);
        n_cmp++; if (rsp_rdata !== 32'h2222_2222) begin n_bad++; $display("FAIL err_no_alias_rd got %h exp 22222222", rsp_rdata); end
        idle_cycles(1);
    endtask

    task automatic test_reset_mid;
        @(negedge clk);
        rsp_ready = 1'b0;
        drive_req(1'b0, 0, 0, 0, 32'h0);
        n_cmp++; if (rsp_valid !== 1'b1) begin n_bad++; $display("FAIL mid_pending got %b exp 1", rsp_valid); end
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        n_cmp++;
        if (rsp_valid !== 1'b0 || rsp_rdata !== 32'h0 || req_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL mid_reset got v=%b d=%h rdy=%b exp v=0 d=0 rdy=1", rsp_valid, rsp_rdata, req_ready);
        end
`ifdef MEM_ERRCNT_EN
        n_cmp++; if (err_cnt !== 16'd0) begin n_bad++; $display("FAIL mid_err_cnt got %0d exp 0", err_cnt); end
`endif
        @(negedge clk);
        rst_n     = 1'b1;
        rsp_ready = 1'b1;
        drive_req(1'b0, 0, 0, 0, 32'h0);
        n_cmp++; if (rsp_rdata !== 32'hDEADBEEF) begin n_bad++; $display("FAIL mid_keep_origin got %h exp deadbeef", rsp_rdata); end
        drive_req(1'b0, 9, 24, 24, 32'h0);
        n_cmp++; if (rsp_rdata !== 32'h1) begin n_bad++; $display("FAIL mid_keep_corner got %h exp 1", rsp_rdata); end
        idle_cycles(1);
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_corners();
        test_stall();
        test_back_to_back();
        test_addr_err();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
